// File: rtl/muldiv_ctrl.sv
// Sequencer for the shared multiply/divide unit: starts the selected unit, times its latency,
// then drives the HI/LO selects and a one-cycle write. Optional macro: DIVZERO_TRAP_EN.
module muldiv_ctrl #(
    parameter int MULT_CYCLES = 32,
    parameter int DIV_CYCLES  = 32
) (
    input  logic clk,
    input  logic reset_n,
    input  logic mult_req,
    input  logic div_req,
    input  logic divisor_zero,
    output logic mult_go,
    output logic div_go,
    output logic lo_sel,
    output logic hi_sel,
    output logic hilo_we,
    output logic busy,
    output logic done,
    output logic div_zero_exc
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MULT  = 2'd1,
        ST_DIV   = 2'd2,
        ST_WRITE = 2'd3
    } state_e;

    // The counter is loaded with N-1 so that the run state lasts exactly N cycles.
    localparam logic [5:0] MULT_LOAD = 6'(MULT_CYCLES - 1);
    localparam logic [5:0] DIV_LOAD  = 6'(DIV_CYCLES - 1);

    state_e     state_q;
    logic [5:0] cnt_q;
    logic       mult_go_q;
    logic       div_go_q;
    logic       sel_q;
    logic       hilo_we_q;
    logic       busy_q;
    logic       done_q;
    logic       div_zero_exc_q;
    logic       trap_req;

`ifdef DIVZERO_TRAP_EN
    assign trap_req = divisor_zero;
`else
    logic unused_divisor_zero;
    assign unused_divisor_zero = divisor_zero;
    assign trap_req            = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            mult_go_q      <= 1'b0;
            div_go_q       <= 1'b0;
            sel_q          <= 1'b0;
            hilo_we_q      <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            div_zero_exc_q <= 1'b0;
        end else begin
            // Pulse outputs default low; only the transitions below raise them.
            mult_go_q      <= 1'b0;
            div_go_q       <= 1'b0;
            hilo_we_q      <= 1'b0;
            done_q         <= 1'b0;
            div_zero_exc_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (mult_req) begin
                        state_q   <= ST_MULT;
                        cnt_q     <= MULT_LOAD;
                        mult_go_q <= 1'b1;
                        sel_q     <= 1'b0;
                        busy_q    <= 1'b1;
                    end else if (div_req) begin
                        sel_q  <= 1'b1;
                        busy_q <= 1'b1;
                        if (trap_req) begin
                            // Skip the divider entirely; WRITE then reports without writing HI/LO.
                            state_q        <= ST_WRITE;
                            done_q         <= 1'b1;
                            div_zero_exc_q <= 1'b1;
                        end else begin
                            state_q  <= ST_DIV;
                            cnt_q    <= DIV_LOAD;
                            div_go_q <= 1'b1;
                        end
                    end
                end
                ST_MULT, ST_DIV: begin
                    if (cnt_q == 6'd0) begin
                        state_q   <= ST_WRITE;
                        hilo_we_q <= 1'b1;
                        done_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 6'd1;
                    end
                end
                ST_WRITE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign mult_go      = mult_go_q;
    assign div_go       = div_go_q;
    assign lo_sel       = sel_q;
    assign hi_sel       = sel_q;
    assign hilo_we      = hilo_we_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign div_zero_exc = div_zero_exc_q;

endmodule
